// File: rtl/audio_pkg.sv
// Shared constants and types for the DECA audio path: sample/frame geometry,
// the default clock plan used by the codec configuration controller, and debug views.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int SLOTS    = 32;
   localparam int FRAME_W  = 2 * SAMPLE_W;
   localparam int SLOT_W   = $clog2(SLOTS);

   // 50 MHz / (2*2) = 12.5 MHz MCLK; 50 MHz / (2*16) = 1.5625 MHz BCLK
   localparam int MCLK_DIV_DEF = 2;
   localparam int BCLK_DIV_DEF = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_t;

   typedef struct packed {
      tx_state_t         state;
      logic [SLOT_W-1:0] slot;
      logic              hold_full;
      logic              frame_load;
      logic              bclk_fall;
      logic              mclk_fall;
   } tx_dbg_t;

   // Upper half of the frame carries the right channel, so WCLK is high there.
   function automatic logic slot_is_right(input logic [SLOT_W-1:0] slot);
      return slot >= SLOT_W'(SLOTS / 2);
   endfunction

endpackage

// File: rtl/audio_clk_div.sv
// Toggle divider: output flips every DIV enabled cycles; o_fall strobes in the
// cycle whose edge takes the output from 1 to 0. Disabled means held at 0.
module audio_clk_div #(
   parameter int DIV = 2
) (
   input  logic CLK_50,
   input  logic RESET_n,
   input  logic i_en,
   output logic o_clk,
   output logic o_fall
);

   localparam int            CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_clk;
   logic          w_tc;

   assign w_tc = i_en && (r_cnt == TC);

   always_ff @(posedge CLK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_cnt <= '0;
         r_clk <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_clk <= 1'b0;
      end else if (w_tc) begin
         r_cnt <= '0;
         r_clk <= ~r_clk;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_clk  = r_clk;
   assign o_fall = w_tc && r_clk;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the codec: generates MCLK/BCLK/WCLK and serialises 16-bit
// stereo samples taken through a one-deep holding register (valid/ready).
//
// Handshake: a pair {iL,iR} transfers on a CLK_50 edge where iVALID && oREADY;
// iVALID may assert at any time, and once a pair is offered the producer holds it
// stable until oREADY is seen high on an edge. oREADY never depends on iVALID.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int MCLK_DIV = MCLK_DIV_DEF,
   parameter int BCLK_DIV = BCLK_DIV_DEF,
   parameter int UNDER_W  = 16
) (
   input  logic                CLK_50,
   input  logic                RESET_n,
   input  logic                iCFG_DONE,
   input  logic [SAMPLE_W-1:0] iL,
   input  logic [SAMPLE_W-1:0] iR,
   input  logic                iVALID,
   output logic                oREADY,
   output logic                oMCLK,
   output logic                oBCLK,
   output logic                oWCLK,
   output logic                oDOUT,
   output logic [UNDER_W-1:0]  oUNDERRUN,
   output tx_dbg_t             oDBG
);

   tx_state_t          r_state;
   tx_state_t          w_state_nxt;
   logic               w_run;
   logic               w_ready;

   logic               w_mclk;
   logic               w_mclk_fall;
   logic               w_bclk;
   logic               w_bclk_fall;

   logic [SLOT_W-1:0]  r_slot;
   logic [SLOT_W-1:0]  w_slot_nxt;
   logic               w_load;
   logic [FRAME_W-1:0] r_sh;
   logic               r_dout;
   logic               r_wclk;

   logic [FRAME_W-1:0] r_hold;
   logic               r_full;
   logic               w_xfer;
   logic [UNDER_W-1:0] r_under;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK_50 or negedge RESET_n) begin
      if (!RESET_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (iCFG_DONE)  w_state_nxt = ST_RUN;
         ST_RUN:  if (!iCFG_DONE) w_state_nxt = ST_IDLE;
         default:                 w_state_nxt = ST_IDLE;
      endcase
   end

   // Losing iCFG_DONE stops the bit clock on the same edge that leaves RUN.
   always_comb begin
      w_run   = 1'b0;
      w_ready = 1'b0;
      if (r_state == ST_RUN) begin
         w_run   = iCFG_DONE;
         w_ready = !r_full;
      end
   end

   // ------------------------------------------------------------- clocks
   audio_clk_div #(.DIV(MCLK_DIV)) u_mclk_div (
      .CLK_50  (CLK_50),
      .RESET_n (RESET_n),
      .i_en    (1'b1),
      .o_clk   (w_mclk),
      .o_fall  (w_mclk_fall)
   );

   audio_clk_div #(.DIV(BCLK_DIV)) u_bclk_div (
      .CLK_50  (CLK_50),
      .RESET_n (RESET_n),
      .i_en    (w_run),
      .o_clk   (w_bclk),
      .o_fall  (w_bclk_fall)
   );

   // ---------------------------------------------------- frame / shifter
   assign w_slot_nxt = r_slot + SLOT_W'(1);
   assign w_load     = w_bclk_fall && (w_slot_nxt == '0);

   always_ff @(posedge CLK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_slot <= '0;
         r_sh   <= '0;
         r_dout <= 1'b0;
         r_wclk <= 1'b0;
      end else if (!w_run) begin
         r_slot <= '0;
         r_sh   <= '0;
         r_dout <= 1'b0;
         r_wclk <= 1'b0;
      end else if (w_bclk_fall) begin
         r_dout <= r_sh[FRAME_W-1];
         r_slot <= w_slot_nxt;
         r_wclk <= slot_is_right(w_slot_nxt);
         if (w_load) r_sh <= r_full ? r_hold : '0;
         else        r_sh <= {r_sh[FRAME_W-2:0], 1'b0};
      end
   end

   // ---------------------------------------------- holding register / underrun
   assign w_xfer = iVALID && w_ready;

   // A load and a transfer can share an edge only when the register was empty,
   // so the transfer simply wins and the new pair waits for the next frame.
   always_ff @(posedge CLK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_full <= 1'b0;
         r_hold <= '0;
      end else if (!w_run) begin
         r_full <= 1'b0;
      end else begin
         if (w_load) r_full <= 1'b0;
         if (w_xfer) begin
            r_full <= 1'b1;
            r_hold <= {iL, iR};
         end
      end
   end

   always_ff @(posedge CLK_50 or negedge RESET_n) begin
      if (!RESET_n) begin
         r_under <= '0;
      end else if (w_run && w_load && !r_full && !(&r_under)) begin
         r_under <= r_under + UNDER_W'(1);
      end
   end

   // ------------------------------------------------------------ outputs
   assign oREADY    = w_ready;
   assign oMCLK     = w_mclk;
   assign oBCLK     = w_bclk;
   assign oWCLK     = r_wclk;
   assign oDOUT     = r_dout;
   assign oUNDERRUN = r_under;

   always_comb begin
      oDBG            = '0;
      oDBG.state      = r_state;
      oDBG.slot       = r_slot;
      oDBG.hold_full  = r_full;
      oDBG.frame_load = w_load;
      oDBG.bclk_fall  = w_bclk_fall;
      oDBG.mclk_fall  = w_mclk_fall;
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: random sample traffic checked every cycle against a
// frame-level model driven by the cycle count since the stream was enabled.
module tb_audio_i2s_tx;
   import audio_pkg::*;

   localparam int UW        = 16;
   localparam int BIT_CYC   = 2 * BCLK_DIV_DEF;   // CLK_50 cycles per BCLK period
   localparam int FRAME_CYC = BIT_CYC * 32;       // CLK_50 cycles per frame
   localparam int UMAX      = (1 << UW) - 1;

   logic          CLK_50    = 1'b0;
   logic          RESET_n   = 1'b1;
   logic          iCFG_DONE = 1'b0;
   logic          iVALID    = 1'b0;
   logic [15:0]   iL        = '0;
   logic [15:0]   iR        = '0;
   logic          oREADY, oMCLK, oBCLK, oWCLK, oDOUT;
   logic [UW-1:0] oUNDERRUN;
   tx_dbg_t       oDBG;
   logic          s_ready, s_mclk, s_bclk, s_wclk, s_dout;
   logic [1:0]    s_under;
   tx_dbg_t       s_dbg;

   audio_i2s_tx #(.UNDER_W(UW)) dut (
      .CLK_50(CLK_50), .RESET_n(RESET_n), .iCFG_DONE(iCFG_DONE),
      .iL(iL), .iR(iR), .iVALID(iVALID), .oREADY(oREADY),
      .oMCLK(oMCLK), .oBCLK(oBCLK), .oWCLK(oWCLK), .oDOUT(oDOUT),
      .oUNDERRUN(oUNDERRUN), .oDBG(oDBG)
   );

   audio_i2s_tx #(.UNDER_W(2)) dut_sat (
      .CLK_50(CLK_50), .RESET_n(RESET_n), .iCFG_DONE(iCFG_DONE),
      .iL(iL), .iR(iR), .iVALID(iVALID), .oREADY(s_ready),
      .oMCLK(s_mclk), .oBCLK(s_bclk), .oWCLK(s_wclk), .oDOUT(s_dout),
      .oUNDERRUN(s_under), .oDBG(s_dbg)
   );

   always #10 CLK_50 = ~CLK_50;

   // ---------------------------------------------------------------- model
   int          n_cmp = 0;
   int          n_bad = 0;
   int          g = 0;          // CLK_50 edges since reset release
   bit          running = 0;
   int          k = 0;          // edges since the enabling edge
   logic [31:0] frames[$];      // frames[j] = word loaded at j-th frame load
   bit          hold_full = 0;
   logic [31:0] hold = '0;
   int          uc = 0;
   bit          last_xfer = 0;

   function automatic logic [4:0] exp_pins();
      int t;
      logic [31:0] f;
      logic m, b, w, d, r;
      m = ((g >> 1) & 1) != 0;
      b = 1'b0; w = 1'b0; d = 1'b0; r = 1'b0;
      if (running) begin
         t = k / BIT_CYC;
         b = ((k / BCLK_DIV_DEF) % 2) == 1;
         w = (t % 32) >= 16;
         if (t > 0) begin
            f = frames[(t - 1) / 32];
            d = f[31 - ((t - 1) % 32)];
         end
         r = !hold_full;
      end
      return {m, b, w, d, r};
   endfunction

   function automatic logic [4:0] obs_pins();
      return {oMCLK, oBCLK, oWCLK, oDOUT, oREADY};
   endfunction

   function automatic logic [1:0] exp_sat();
      return (uc > 3) ? 2'd3 : 2'(uc);
   endfunction

   // One CLK_50 edge: advance the model with the inputs present at the edge,
   // then return at the following falling edge where outputs are sampled.
   task automatic tick();
      bit xfer;
      @(posedge CLK_50);
      g++;
      last_xfer = 0;
      if (running) begin
         if (!iCFG_DONE) begin
            running   = 0;
            hold_full = 0;
         end else begin
            xfer = iVALID && !hold_full;
            k++;
            if (k % FRAME_CYC == 0) begin
               if (hold_full) begin
                  frames.push_back(hold);
                  hold_full = 0;
               end else begin
                  frames.push_back(32'h0);
                  if (uc < UMAX) uc++;
               end
            end
            if (xfer) begin
               hold      = {iL, iR};
               hold_full = 1;
               last_xfer = 1;
            end
         end
      end else if (iCFG_DONE) begin
         running = 1;
         k       = 0;
         frames.delete();
         frames.push_back(32'h0);
      end
      @(negedge CLK_50);
   endtask

   task automatic drive(input bit feed);
      if (!feed) begin
         iVALID = 1'b0;
      end else if (!iVALID || last_xfer) begin
         iVALID = 1'b1;
         iL     = 16'($urandom);
         iR     = 16'($urandom);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      #5 RESET_n = 1'b0;
      repeat (3) @(negedge CLK_50);
      n_cmp++;
      if ({obs_pins(), oUNDERRUN} !== {5'b0, 16'h0}) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b/%h exp=00000/0000", obs_pins(), oUNDERRUN);
      end
      n_cmp++;
      if (oDBG.state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL reset_state got=%0d exp=%0d", oDBG.state, ST_IDLE);
      end
      RESET_n = 1'b1;
      g = 0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL idle_pins g=%0d got=%b exp=%b", g, obs_pins(), exp_pins());
         end
         n_cmp++;
         if (oUNDERRUN !== UW'(0) || s_under !== 2'd0) begin
            n_bad++;
            $display("FAIL idle_underrun got=%0d/%0d exp=0/0", oUNDERRUN, s_under);
         end
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] word = '0;
      logic [31:0] wpat = '0;
      int t;
      iCFG_DONE = 1'b1;
      iL = 16'hA5C3;
      iR = 16'h0F01;
      iVALID = 1'b1;
      for (int c = 0; c <= 2 * FRAME_CYC + 100; c++) begin
         tick();
         if (last_xfer) iVALID = 1'b0;
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL frame_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         t = k / BIT_CYC;
         if (k % BIT_CYC == BCLK_DIV_DEF && t >= 33 && t <= 64) begin
            word = {word[30:0], oDOUT};
            wpat = {wpat[30:0], oWCLK};
         end
      end
      n_cmp++;
      if (word !== 32'hA5C30F01) begin
         n_bad++;
         $display("FAIL frame_word got=%h exp=a5c30f01", word);
      end
      n_cmp++;
      if (wpat !== 32'h0001FFFE) begin
         n_bad++;
         $display("FAIL frame_wclk got=%h exp=0001fffe", wpat);
      end
   endtask

   task automatic test_underrun();
      for (int c = 0; c < 3 * FRAME_CYC && k < 4 * FRAME_CYC + 64; c++) begin
         tick();
         drive(0);
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL underrun_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         n_cmp++;
         if (oUNDERRUN !== UW'(uc) || s_under !== exp_sat()) begin
            n_bad++;
            $display("FAIL underrun_count k=%0d got=%0d/%0d exp=%0d/%0d", k, oUNDERRUN, s_under, uc, exp_sat());
         end
      end
      n_cmp++;
      if (oUNDERRUN !== UW'(3) || s_under !== 2'd3) begin
         n_bad++;
         $display("FAIL underrun_three got=%0d/%0d exp=3/3", oUNDERRUN, s_under);
      end
   endtask

   task automatic test_back_to_back();
      int busy = 0;
      for (int c = 0; c < 6 * FRAME_CYC; c++) begin
         tick();
         drive(1);
         if (!oREADY) busy++;
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL b2b_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         n_cmp++;
         if (oUNDERRUN !== UW'(uc)) begin
            n_bad++;
            $display("FAIL b2b_underrun k=%0d got=%0d exp=%0d", k, oUNDERRUN, uc);
         end
      end
      n_cmp++;
      if (oUNDERRUN !== UW'(3) || busy < 5 * FRAME_CYC) begin
         n_bad++;
         $display("FAIL b2b_summary underrun=%0d busy=%0d exp underrun=3 busy>=%0d", oUNDERRUN, busy, 5 * FRAME_CYC);
      end
   endtask

   task automatic test_clock_rates();
      int   last_b  = -1;
      int   last_wr = -1;
      logic pb, pw;
      pb = oBCLK;
      pw = oWCLK;
      for (int c = 0; c < 2600; c++) begin
         tick();
         drive(1);
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL rate_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         if (oBCLK && !pb) begin
            if (last_b >= 0) begin
               n_cmp++;
               if (c - last_b != BIT_CYC) begin
                  n_bad++;
                  $display("FAIL bclk_period got=%0d exp=%0d", c - last_b, BIT_CYC);
               end
            end
            last_b = c;
         end
         if (!oWCLK && pw && last_wr >= 0) begin
            n_cmp++;
            if (c - last_wr != FRAME_CYC / 2) begin
               n_bad++;
               $display("FAIL wclk_high got=%0d exp=%0d", c - last_wr, FRAME_CYC / 2);
            end
         end
         if (oWCLK && !pw) begin
            if (last_wr >= 0) begin
               n_cmp++;
               if (c - last_wr != FRAME_CYC) begin
                  n_bad++;
                  $display("FAIL wclk_period got=%0d exp=%0d", c - last_wr, FRAME_CYC);
               end
            end
            last_wr = c;
         end
         pb = oBCLK;
         pw = oWCLK;
      end
      n_cmp++;
      if (last_b < 0 || last_wr < 0) begin
         n_bad++;
         $display("FAIL rate_edges bclk_rise=%0d wclk_rise=%0d exp both seen", last_b, last_wr);
      end
   endtask

   task automatic test_disable();
      bit found = 0;
      int u0;
      for (int c = 0; c < 2 * FRAME_CYC; c++) begin
         tick();
         drive(1);
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL dis_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         if (running && k % BIT_CYC == 0 && (k / BIT_CYC) % 32 == 9) begin
            found = 1;
            break;
         end
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL dis_slot9 got=not_reached exp=reached");
      end
      u0 = uc;
      iCFG_DONE = 1'b0;
      iVALID    = 1'b0;
      tick();
      n_cmp++;
      if ({oBCLK, oWCLK, oDOUT, oREADY} !== 4'b0) begin
         n_bad++;
         $display("FAIL dis_outputs got=%b exp=0000", {oBCLK, oWCLK, oDOUT, oREADY});
      end
      n_cmp++;
      if (oDBG.state !== ST_IDLE || oUNDERRUN !== UW'(u0)) begin
         n_bad++;
         $display("FAIL dis_state state=%0d underrun=%0d exp=%0d/%0d", oDBG.state, oUNDERRUN, ST_IDLE, u0);
      end
      for (int c = 0; c < 100; c++) begin
         tick();
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL dis_idle_pins g=%0d got=%b exp=%b", g, obs_pins(), exp_pins());
         end
      end
      iCFG_DONE = 1'b1;
      for (int c = 0; c < FRAME_CYC + 40; c++) begin
         tick();
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL reen_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         if (k == FRAME_CYC - 1) begin
            n_cmp++;
            if (oUNDERRUN !== UW'(u0)) begin
               n_bad++;
               $display("FAIL reen_before_load got=%0d exp=%0d", oUNDERRUN, u0);
            end
         end
         if (k == FRAME_CYC) begin
            n_cmp++;
            if (oUNDERRUN !== UW'(u0 + 1)) begin
               n_bad++;
               $display("FAIL reen_first_load got=%0d exp=%0d", oUNDERRUN, u0 + 1);
            end
         end
      end
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 5 * FRAME_CYC && k < 5 * FRAME_CYC + 40; c++) begin
         tick();
         drive(0);
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL sat_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
         n_cmp++;
         if (oUNDERRUN !== UW'(uc) || s_under !== exp_sat()) begin
            n_bad++;
            $display("FAIL sat_count k=%0d got=%0d/%0d exp=%0d/%0d", k, oUNDERRUN, s_under, uc, exp_sat());
         end
      end
      n_cmp++;
      if (s_under !== 2'd3 || uc < 5) begin
         n_bad++;
         $display("FAIL sat_hold got=%0d exp=3 (starved=%0d)", s_under, uc);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int c = 0; c < 300; c++) begin
         tick();
         drive(1);
         n_cmp++;
         if (obs_pins() !== exp_pins()) begin
            n_bad++;
            $display("FAIL mid_pins k=%0d got=%b exp=%b", k, obs_pins(), exp_pins());
         end
      end
      #3 RESET_n = 1'b0;
      #1;
      n_cmp++;
      if ({obs_pins(), oUNDERRUN, s_under} !== {5'b0, 16'h0, 2'b0}) begin
         n_bad++;
         $display("FAIL mid_reset got=%b/%0d/%0d exp=00000/0/0", obs_pins(), oUNDERRUN, s_under);
      end
      n_cmp++;
      if (oDBG.state !== ST_IDLE || oDBG.slot !== '0 || oDBG.hold_full !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_state got=%0d/%0d/%0d exp=0/0/0", oDBG.state, oDBG.slot, oDBG.hold_full);
      end
      iVALID    = 1'b0;
      iCFG_DONE = 1'b0;
      running   = 0;
      hold_full = 0;
      uc        = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_underrun();
      test_back_to_back();
      test_clock_rates();
      test_disable();
      test_saturation();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
